// File: rtl/rst_seq_ctrl.sv
// rst_seq_ctrl - reset sequencer for the always-on clock/reset subsystem.
//
// Holds all downstream reset domains low for HOLD_CYC cycles, then releases
// them one by one (bit 0 first) with GAP_CYC cycles between releases. A
// software or watchdog request restarts the whole sequence from HOLD.
//
// Optional feature (macro RST_SEQ_CTRL_ACK_EN): each released domain must
// acknowledge (ack_i) before the next one is released. If the ack is still
// missing ACK_TO cycles after the gap ends, the sticky err_o flag is set and
// the sequence continues anyway.
//
// Ports:
//   clk_i          always-on clock
//   rst_n_i        asynchronous active-low reset (power-on / external)
//   sw_rst_req_i   software reset request (pulse or level)
//   wdt_rst_req_i  watchdog reset request (pulse or level)
//   rst_n_o        per-domain active-low reset, registered
//   busy_o         sequence in progress
//   done_o         all domains released (and acked, with the ack feature)
//   cause_o        last reset cause: 00 ext, 01 sw, 10 wdt
//   ack_i          per-domain out-of-reset ack (RST_SEQ_CTRL_ACK_EN only)
//   err_o          sticky ack-timeout flag    (RST_SEQ_CTRL_ACK_EN only)
module rst_seq_ctrl #(
  parameter int DOMAIN_NUM = 4,
  parameter int HOLD_CYC   = 16,
  parameter int GAP_CYC    = 8,
  parameter int ACK_TO     = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  sw_rst_req_i,
  input  logic                  wdt_rst_req_i,
  output logic [DOMAIN_NUM-1:0] rst_n_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [1:0]            cause_o
`ifdef RST_SEQ_CTRL_ACK_EN
  ,
  input  logic [DOMAIN_NUM-1:0] ack_i,
  output logic                  err_o
`endif
);

  localparam int MAX_HG = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
  localparam int MAX_C  = (MAX_HG > ACK_TO) ? MAX_HG : ACK_TO;
  localparam int CNT_W  = $clog2(MAX_C + 1);
  localparam int IDX_W  = (DOMAIN_NUM > 1) ? $clog2(DOMAIN_NUM) : 1;

  typedef enum logic [1:0] {HOLD, REL, DONE} state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DOMAIN_NUM-1:0] rst_q, rst_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [1:0]            cause_q, cause_d;

  logic req, hold_end, gap_end, last_idx;
  logic step;  // release domain idx (or leave REL when idx is the last one)

  assign req      = sw_rst_req_i | wdt_rst_req_i;
  assign hold_end = (cnt_q == CNT_W'(HOLD_CYC - 1));
  assign gap_end  = (cnt_q == CNT_W'(GAP_CYC - 1));
  assign last_idx = (idx_q == IDX_W'(DOMAIN_NUM - 1));

`ifdef RST_SEQ_CTRL_ACK_EN
  // wait_q: gap has elapsed but the previous domain has not acked yet; the
  // counter is reused from 0 to time out the ack, so it never exceeds ACK_TO.
  logic wait_q, wait_d;
  logic err_q, err_d;
  logic ack_prev, ack_last, to_end;

  assign ack_prev = ack_i[idx_q - IDX_W'(1)];
  assign ack_last = ack_i[DOMAIN_NUM-1];
  assign to_end   = (cnt_q == CNT_W'(ACK_TO - 1));
  assign step     = wait_q ? (ack_prev | to_end) : (gap_end & ack_prev);
`else
  assign step     = gap_end;
`endif

  // State register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= HOLD;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (req) begin
      state_d = HOLD;
    end else begin
      case (state_q)
        HOLD:    if (hold_end) state_d = (DOMAIN_NUM == 1) ? DONE : REL;
        REL:     if (step && last_idx) state_d = DONE;
        DONE:    state_d = DONE;
        default: state_d = HOLD;
      endcase
    end
  end

  // Output / datapath next values (all outputs are registered below)
  always_comb begin
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rst_d   = rst_q;
    done_d  = done_q;
    cause_d = cause_q;
`ifdef RST_SEQ_CTRL_ACK_EN
    wait_d  = wait_q;
    err_d   = err_q;
`endif
    if (req) begin
      cnt_d   = '0;
      idx_d   = '0;
      rst_d   = '0;
      done_d  = 1'b0;
      cause_d = wdt_rst_req_i ? 2'b10 : 2'b01;  // wdt wins a tie
`ifdef RST_SEQ_CTRL_ACK_EN
      wait_d  = 1'b0;
`endif
    end else begin
      case (state_q)
        HOLD: begin
          if (hold_end) begin
            rst_d[0] = 1'b1;
            idx_d    = IDX_W'(1);
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        REL: begin
          if (step) begin
            for (int i = 0; i < DOMAIN_NUM; i++)
              if (idx_q == IDX_W'(i)) rst_d[i] = 1'b1;
            cnt_d = '0;
            if (!last_idx) idx_d = idx_q + IDX_W'(1);
`ifdef RST_SEQ_CTRL_ACK_EN
            wait_d = 1'b0;
            if (wait_q && !ack_prev) err_d = 1'b1;
          end else if (gap_end && !wait_q) begin
            wait_d = 1'b1;
            cnt_d  = '0;
`endif
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        DONE: begin
`ifdef RST_SEQ_CTRL_ACK_EN
          // The last domain's ack gates done_o, timed from DONE entry.
          if (!done_q) begin
            if (ack_last || to_end) begin
              done_d = 1'b1;
              if (!ack_last) err_d = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
`else
          done_d = 1'b1;
`endif
        end
        default: ;
      endcase
    end
    busy_d = ~done_d;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      rst_q   <= '0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
      cause_q <= 2'b00;
`ifdef RST_SEQ_CTRL_ACK_EN
      wait_q  <= 1'b0;
      err_q   <= 1'b0;
`endif
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rst_q   <= rst_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cause_q <= cause_d;
`ifdef RST_SEQ_CTRL_ACK_EN
      wait_q  <= wait_d;
      err_q   <= err_d;
`endif
    end
  end

  assign rst_n_o = rst_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign cause_o = cause_q;
`ifdef RST_SEQ_CTRL_ACK_EN
  assign err_o   = err_q;
`endif

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Testbench for rst_seq_ctrl (default parameters). Reference model: each
// domain's release is a pure function of edges elapsed since the sequence
// start (reset release or last sampled request).
module tb_rst_seq_ctrl;
  localparam int N = 4, H = 16, G = 8, TO = 64;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         sw = 1'b0, wdt = 1'b0;
  logic [N-1:0] rst_n_o;
  logic         busy, done;
  logic [1:0]   cause;
`ifdef RST_SEQ_CTRL_ACK_EN
  logic [N-1:0] ack = '1;
  logic         err;
`endif

  int errors = 0, checks = 0;
  int edge_n = 0, start = 0;
  logic [1:0] m_cause = 2'b00;
  bit model_on = 1'b1;

  always #5 clk = ~clk;

  rst_seq_ctrl #(.DOMAIN_NUM(N), .HOLD_CYC(H), .GAP_CYC(G), .ACK_TO(TO)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .sw_rst_req_i(sw), .wdt_rst_req_i(wdt),
    .rst_n_o(rst_n_o), .busy_o(busy), .done_o(done), .cause_o(cause)
`ifdef RST_SEQ_CTRL_ACK_EN
    , .ack_i(ack), .err_o(err)
`endif
  );

  typedef struct {
    logic       sw, wdt;
    int         n;
    logic [N-1:0] rst;
    logic       done;
    logic [1:0] cause;
  } vec_t;
  vec_t tbl[$];

  function automatic logic [N-1:0] exp_rst(int e);
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = (e >= H + i * G);
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // One clock: drive at negedge, model on posedge, compare at next negedge.
  task automatic cyc(input logic s, input logic w);
    int e;
    sw = s; wdt = w;
    @(posedge clk);
    edge_n++;
    if (s | w) begin
      start = edge_n;
      m_cause = w ? 2'b10 : 2'b01;
    end
    @(negedge clk);
    if (model_on) begin
      e = edge_n - start;
      chk("model rst_n_o", 32'(rst_n_o), 32'(exp_rst(e)));
      chk("model done_o", 32'(done), 32'(e >= H + (N - 1) * G + 1));
      chk("model busy_o", 32'(busy), 32'(!(e >= H + (N - 1) * G + 1)));
      chk("model cause_o", 32'(cause), 32'(m_cause));
    end
  endtask

  // Async reset pulse mid-cycle: outputs must clear before any clock edge.
  task automatic do_reset();
    sw = 1'b0; wdt = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async rst_n_o", 32'(rst_n_o), 32'(0));
    chk("async cause_o", 32'(cause), 32'(0));
    chk("async busy_o", 32'(busy), 32'(1));
    chk("async done_o", 32'(done), 32'(0));
`ifdef RST_SEQ_CTRL_ACK_EN
    chk("async err_o", 32'(err), 32'(0));
`endif
    @(negedge clk);
    rst_n = 1'b1;
    edge_n = 0; start = 0; m_cause = 2'b00;
  endtask

  initial begin
    // Power-on reset state
    repeat (3) @(negedge clk);
    chk("reset rst_n_o", 32'(rst_n_o), 32'(0));
    chk("reset busy_o", 32'(busy), 32'(1));
    chk("reset done_o", 32'(done), 32'(0));
    chk("reset cause_o", 32'(cause), 32'(0));
    rst_n = 1'b1;

    // Scenarios 1-4 as vectors: {sw, wdt, cycles, rst_n_o, done_o, cause_o}
    tbl.push_back('{1'b0, 1'b0, 15, 4'b0000, 1'b0, 2'b00});
    tbl.push_back('{1'b0, 1'b0, 1,  4'b0001, 1'b0, 2'b00});  // edge 16
    tbl.push_back('{1'b0, 1'b0, 7,  4'b0001, 1'b0, 2'b00});
    tbl.push_back('{1'b0, 1'b0, 1,  4'b0011, 1'b0, 2'b00});  // edge 24
    tbl.push_back('{1'b0, 1'b0, 8,  4'b0111, 1'b0, 2'b00});  // edge 32
    tbl.push_back('{1'b0, 1'b0, 8,  4'b1111, 1'b0, 2'b00});  // edge 40
    tbl.push_back('{1'b0, 1'b0, 1,  4'b1111, 1'b1, 2'b00});  // edge 41
    tbl.push_back('{1'b1, 1'b0, 1,  4'b0000, 1'b0, 2'b01});  // sw pulse
    tbl.push_back('{1'b0, 1'b0, 15, 4'b0000, 1'b0, 2'b01});
    tbl.push_back('{1'b0, 1'b0, 1,  4'b0001, 1'b0, 2'b01});
    tbl.push_back('{1'b0, 1'b0, 8,  4'b0011, 1'b0, 2'b01});  // mid-REL
    tbl.push_back('{1'b0, 1'b1, 1,  4'b0000, 1'b0, 2'b10});  // wdt pulse
    tbl.push_back('{1'b0, 1'b0, 15, 4'b0000, 1'b0, 2'b10});
    tbl.push_back('{1'b0, 1'b0, 1,  4'b0001, 1'b0, 2'b10});
    tbl.push_back('{1'b0, 1'b0, 24, 4'b1111, 1'b0, 2'b10});
    tbl.push_back('{1'b0, 1'b0, 1,  4'b1111, 1'b1, 2'b10});
    tbl.push_back('{1'b1, 1'b1, 1,  4'b0000, 1'b0, 2'b10});  // tie: wdt
    tbl.push_back('{1'b1, 1'b0, 30, 4'b0000, 1'b0, 2'b01});  // sw level
    tbl.push_back('{1'b0, 1'b0, 15, 4'b0000, 1'b0, 2'b01});
    tbl.push_back('{1'b0, 1'b0, 1,  4'b0001, 1'b0, 2'b01});
    tbl.push_back('{1'b0, 1'b0, 25, 4'b1111, 1'b1, 2'b01});

    foreach (tbl[i]) begin
      repeat (tbl[i].n) cyc(tbl[i].sw, tbl[i].wdt);
      chk($sformatf("vec%0d rst_n_o", i), 32'(rst_n_o), 32'(tbl[i].rst));
      chk($sformatf("vec%0d done_o", i), 32'(done), 32'(tbl[i].done));
      chk($sformatf("vec%0d busy_o", i), 32'(busy), 32'(!tbl[i].done));
      chk($sformatf("vec%0d cause_o", i), 32'(cause), 32'(tbl[i].cause));
    end

    // Scenario 5: async reset mid-REL (cause is 10 before, 00 after)
    cyc(1'b0, 1'b1);
    repeat (26) cyc(1'b0, 1'b0);
    chk("pre-reset rst_n_o", 32'(rst_n_o), 32'(4'b0011));
    do_reset();
    repeat (20) cyc(1'b0, 1'b0);

`ifdef RST_SEQ_CTRL_ACK_EN
    // Scenario 6: ack[1] stuck low delays domain 2 by ACK_TO cycles
    begin
      int t2 = -1, td = -1;
      do_reset();
      model_on = 1'b0;
      ack = 4'b1101;
      for (int k = 0; k < 200; k++) begin
        cyc(1'b0, 1'b0);
        if (rst_n_o[2] && t2 < 0) t2 = edge_n;
        if (done && td < 0) td = edge_n;
      end
      chk("ack rst2 edge", 32'(t2), 32'(H + 2 * G + TO));
      chk("ack done edge", 32'(td), 32'(H + 3 * G + TO + 1));
      chk("ack err_o", 32'(err), 32'(1));
      ack = '1;
      do_reset();
      model_on = 1'b1;
      repeat (45) cyc(1'b0, 1'b0);
      chk("ack-ok err_o", 32'(err), 32'(0));
    end
`endif

    // Randomized requests, level holds and async resets vs the model
    for (int k = 0; k < 300; k++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 3)       cyc(1'b1, 1'b0);
      else if (r < 6)  cyc(1'b0, 1'b1);
      else if (r < 7)  cyc(1'b1, 1'b1);
      else if (r < 8)  do_reset();
      else if (r < 10) repeat ($urandom_range(2, 20)) cyc(1'b1, 1'b0);
      repeat ($urandom_range(1, 60)) cyc(1'b0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
